// File: rtl/fir_tap_sequencer_pkg.sv
// Shared types and sizing helpers for the time-multiplexed FIR tap sequencer.
package fir_tap_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Room for TAPS full-scale NxN products, so the accumulator can never wrap.
  function automatic int acc_width(input int n, input int taps);
    return 2 * n + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Sample-in / coefficient-rom / result-out bundle of the FIR tap sequencer.
interface fir_tap_sequencer_if
  import fir_tap_sequencer_pkg::*;
#(
  parameter int N    = 8,
  parameter int TAPS = 8
);
  localparam int ACC_W = acc_width(N, TAPS);

  logic                    in_valid;
  logic signed [N-1:0]     in_data;
  logic                    in_ready;
  logic [N-1:0]            rom_addr;
  logic signed [N-1:0]     rom_data;
  logic                    out_valid;
  logic signed [ACC_W-1:0] out_data;
  logic                    busy;

  // master is the sequencer itself; slave is the source/rom/sink around it.
  modport master (
    input  in_valid, in_data, rom_data,
    output in_ready, rom_addr, out_valid, out_data, busy
  );

  modport slave (
    output in_valid, in_data, rom_data,
    input  in_ready, rom_addr, out_valid, out_data, busy
  );

endinterface

// File: rtl/fir_tap_sequencer_delay_line.sv
// Circular sample history: TAPS x N registers, one write port, one async read port.
module fir_delay_line #(
  parameter int N    = 8,
  parameter int TAPS = 8,
  parameter int KW   = $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [KW-1:0]       wr_idx,
  input  logic signed [N-1:0] wr_data,
  input  logic [KW-1:0]       rd_idx,
  output logic signed [N-1:0] rd_data
);

  logic signed [N-1:0] mem [TAPS];

  // Clearing on reset makes the first outputs partial sums over zero history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < TAPS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR controller: per accepted sample, walks the coefficient rom over all taps
// through one shared multiply-accumulate and emits one result.
module fir_tap_sequencer
  import fir_tap_sequencer_pkg::*;
#(
  parameter int N     = 8,
  parameter int TAPS  = 8,
  parameter int ACC_W = acc_width(N, TAPS)
) (
  input  logic clk,
  input  logic reset,
  fir_tap_sequencer_if.master bus
);

  localparam int KW = $clog2(TAPS);

  state_t                  state;
  logic [KW-1:0]           k;
  logic [KW-1:0]           wr_ptr;
  logic [KW-1:0]           wr_idx;
  logic [KW-1:0]           rd_idx;
  logic                    wr_en;
  logic signed [N-1:0]     rd_data;
  logic signed [N-1:0]     sample_d;
  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;

  assign wr_en  = (state == IDLE) && bus.in_valid;
  assign wr_idx = wr_ptr + KW'(1);
  assign rd_idx = wr_ptr - k;

  fir_delay_line #(
    .N    (N),
    .TAPS (TAPS),
    .KW   (KW)
  ) u_delay_line (
    .clk     (clk),
    .reset   (reset),
    .we      (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (bus.in_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  assign prod     = sample_d * bus.rom_data;
  assign prod_ext = {{(ACC_W - 2*N){prod[2*N-1]}}, prod};
  assign acc_sum  = acc + prod_ext;

  // The sample is registered alongside the rom's registered read, so the
  // product of tap k lands two edges after its address is issued; DRAIN and
  // DONE absorb the last two products of the pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      k             <= '0;
      wr_ptr        <= '0;
      acc           <= '0;
      sample_d      <= '0;
      bus.rom_addr  <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            wr_ptr       <= wr_idx;
            acc          <= '0;
            k            <= '0;
            bus.rom_addr <= '0;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= MAC;
          end
        end
        MAC: begin
          sample_d <= rd_data;
          if (k != '0) begin
            acc <= acc_sum;
          end
          k            <= k + KW'(1);
          bus.rom_addr <= N'(k) + N'(1);
          if (k == KW'(TAPS - 2)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          sample_d <= rd_data;
          acc      <= acc_sum;
          state    <= DONE;
        end
        DONE: begin
          acc           <= acc_sum;
          bus.out_data  <= acc_sum;
          bus.out_valid <= 1'b1;
          bus.in_ready  <= 1'b1;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
